// File: rtl/mux_rr_pkg.sv
// Shared constants and the round-robin search used by the N-channel registered mux.
// rr_pick scans from ptr upward, wrapping at n rather than at a power of two.
package mux_rr_pkg;

   localparam int unsigned DefWidth = 32;
   localparam int unsigned MinN     = 2;
   localparam int unsigned MaxN     = 16;
   localparam int unsigned IdxW     = 4;

   typedef struct packed {
      logic            found;
      logic [IdxW-1:0] idx;
   } rr_pick_t;

   function automatic rr_pick_t rr_pick(input logic [MaxN-1:0] req,
                                        input logic [IdxW-1:0] ptr,
                                        input int              n);
      rr_pick_t res;
      int       k;
      res = '0;
      // Walk offsets from farthest to nearest so the last hit is the closest to ptr.
      for (int i = int'(MaxN) - 1; i >= 0; i--) begin
         if (i < n) begin
            k = int'(ptr) + i;
            if (k >= n) begin
               k = k - n;
            end
            if (req[k[IdxW-1:0]]) begin
               res.found = 1'b1;
               res.idx   = k[IdxW-1:0];
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant with an optional lock that pins the grant to one channel.
module rr_arbiter
   import mux_rr_pkg::*;
#(
   parameter int unsigned N    = 4,
   parameter int unsigned SELW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    i_req,
   input  logic [SELW-1:0] i_ptr,
   input  logic            i_lock,
   input  logic [SELW-1:0] i_lock_ch,
   output logic [SELW-1:0] o_gnt_idx,
   output logic            o_gnt_vld
);

   rr_pick_t w_pick;

   always_comb begin
      w_pick = rr_pick(MaxN'(i_req), IdxW'(i_ptr), int'(N));
      if (i_lock) begin
         // A locked transfer waits for its own channel even if others are requesting.
         o_gnt_idx = i_lock_ch;
         o_gnt_vld = i_req[i_lock_ch];
      end else begin
         o_gnt_idx = SELW'(w_pick.idx);
         o_gnt_vld = w_pick.found;
      end
   end

endmodule

// File: rtl/mux_rr_reg.sv
// N-channel round-robin multiplexer with a registered valid/ready output stage.
// Multi-beat transfers (last=0) lock the grant until the channel's last beat.
module mux_rr_reg
   import mux_rr_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned N     = 4,
   parameter int unsigned SELW  = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_last,
   output logic [SELW-1:0]    out_sel
);

   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic             r_out_last;
   logic [SELW-1:0]  r_out_sel;
   logic [SELW-1:0]  r_rr_ptr;
   logic             r_lock;
   logic [SELW-1:0]  r_lock_ch;

   logic             w_load_en;
   logic             w_accept;
   logic             w_gnt_vld;
   logic [SELW-1:0]  w_gnt_idx;
   logic [WIDTH-1:0] w_gnt_data;
   logic             w_gnt_last;
   logic [SELW-1:0]  w_ptr_nxt;

   rr_arbiter #(
      .N    (N),
      .SELW (SELW)
   ) u_arb (
      .i_req     (in_valid),
      .i_ptr     (r_rr_ptr),
      .i_lock    (r_lock),
      .i_lock_ch (r_lock_ch),
      .o_gnt_idx (w_gnt_idx),
      .o_gnt_vld (w_gnt_vld)
   );

   assign w_load_en = !r_out_valid || out_ready;
   assign w_accept  = reset && w_load_en && w_gnt_vld;
   assign w_ptr_nxt = (w_gnt_idx == SELW'(N - 1)) ? '0 : w_gnt_idx + 1'b1;

   always_comb begin
      in_ready   = '0;
      w_gnt_data = '0;
      w_gnt_last = 1'b0;
      for (int k = 0; k < int'(N); k++) begin
         if (w_gnt_idx == SELW'(k)) begin
            in_ready[k] = w_accept;
            w_gnt_data  = in_data[k*WIDTH +: WIDTH];
            w_gnt_last  = in_last[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_out_sel   <= '0;
         r_rr_ptr    <= '0;
         r_lock      <= 1'b0;
         r_lock_ch   <= '0;
      end else begin
         if (w_load_en) begin
            r_out_valid <= w_accept;
         end
         if (w_accept) begin
            r_out_data <= w_gnt_data;
            r_out_last <= w_gnt_last;
            r_out_sel  <= w_gnt_idx;
            // The pointer only advances once a whole transfer has gone through.
            if (w_gnt_last) begin
               r_lock   <= 1'b0;
               r_rr_ptr <= w_ptr_nxt;
            end else begin
               r_lock    <= 1'b1;
               r_lock_ch <= w_gnt_idx;
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign out_sel   = r_out_sel;

endmodule
